code_digit_reader: RTL and testbench
====================================

# code_digit_reader

Parallel-in, digit-serial-out reader for the lock's 16-bit entered-code word: four 4-bit keypad digits, with the oldest digit in bits [3:0]. On `start` it captures the word and presents the digits one at a time, oldest first, over a valid/ready handshake. It sits between the code-entry shift register and downstream digit consumers: display scanner, serial comparator, logging UART. When the last digit is taken it pulses `done`.

## Interface
- DIGITS, 4, number of digits in the code word
- DIGIT_W, 4, bits per digit; code width CODE_W = DIGITS*DIGIT_W
- clk  in  1  rising-edge clock
- clr  in  1  reset, synchronous, active-high
- start  in  1  capture `code_i` and begin unloading (honoured only in IDLE)
- code_i  in  CODE_W  code word; digit k occupies bits [k*DIGIT_W +: DIGIT_W], k=0 oldest
- digit_o  out  DIGIT_W  current digit; 0 whenever `digit_valid`=0
- digit_valid  out  1  `digit_o` is valid
- digit_ready  in  1  consumer accepts `digit_o` this cycle
- digit_idx  out  clog2(DIGITS) (min 1)  index of the digit on `digit_o`; 0 when idle
- busy  out  1  high in SEND and DONE
- done  out  1  one-cycle pulse after the last digit is accepted
- Reset values: digit_o=0, digit_valid=0, digit_idx=0, busy=0, done=0, state=IDLE, shift register=0

## Operation
- States: IDLE, SEND, DONE.
- IDLE: all outputs at reset values.
  - `start`=1: load shift register with `code_i`, set count to 0, go to SEND.
- SEND: digit_valid=1, digit_o=sreg[DIGIT_W-1:0], digit_idx=count.
  - Handshake fires when digit_valid && digit_ready.
  - On a handshake, shift sreg right by DIGIT_W with zero fill and increment count.
  - If the handshake happens with count==DIGITS-1, go to DONE instead.
  - With digit_ready=0, digit_o, digit_idx and sreg hold unchanged indefinitely. No timeout.
- DONE: digit_valid=0, done=1 for exactly one cycle, busy=1, then go to IDLE.
- `start` in SEND or DONE is ignored; no queueing, and the captured word is unaffected.
- `code_i` is sampled only on the accepted-start edge; later changes have no effect.
- `clr` overrides everything, including a simultaneous `start` or handshake. Next state is IDLE with reset values, and no `done` is issued for an aborted transfer.
- Count is never allowed to wrap: DIGITS handshakes exactly per transfer.

## Timing
- Start is sampled at edge N. digit_valid=1 and digit 0 are visible from edge N+1; there is no combinational start-to-valid path.
- With digit_ready held at 1: one digit per cycle, digits 0..3 in cycles N+1..N+4. `done` is high in cycle N+5; IDLE from N+6.
- Minimum start-to-start period: 6 cycles (DIGITS+2).
- Outputs are registered or decoded from state/registers only. digit_ready affects only next state, not current outputs.
- digit_valid never drops without a handshake, except on `clr`.

## Structure
- Shared include `zamek_defs.vh` holds:
  - DIGITS and DIGIT_W defaults;
  - CODE_W;
  - state encodings ST_IDLE=2'd0, ST_SEND=2'd1, ST_DONE=2'd2, 2'd3 illegal → IDLE.
- Natural sub-module: `digit_stage`, a DIGIT_W-bit register with sync clr, load and shift-select.
  - The top instantiates DIGITS of them chained high-to-low, mirroring the entry register.
  - The top also holds the FSM and the counter.

## Test plan
- Reset: assert clr 2 cycles → all outputs 0, busy=0; `start` during clr → still IDLE after release.
- Basic unload: code_i=16'h4321, start 1 cycle, ready=1 → digit_o 1,2,3,4 with idx 0..3 in consecutive cycles; done pulse in 5th cycle after start; busy=0 in 6th.
- Backpressure: code_i=16'hA5C3, ready low for 3 cycles on each digit → digit_o 3 held stable each stall, then 3,C,5,A in order; exactly one done.
- Ignored start: start re-asserted with code_i=16'hFFFF mid-transfer of 16'h1234 → output still 4,3,2,1; no second transfer.
- Abort: clr after the second handshake of 16'h8765 → next cycle valid=0, busy=0, no done; new start with 16'h0009 → 9,0,0,0.
- Back-to-back: start held high continuously with ready=1 → a new transfer begins every 6 cycles, each capturing code_i at its own start edge.

Source files
------------

// File: rtl/code_digit_reader_pkg.sv
// Shared constants, FSM state encoding and width helper for the code digit reader.
package code_digit_reader_pkg;

  localparam int DIGITS_DEF  = 4;
  localparam int DIGIT_W_DEF = 4;
  localparam int CODE_W_DEF  = DIGITS_DEF * DIGIT_W_DEF;

  // Unused encoding 2'd3 is treated as illegal and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a digit counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/code_digit_reader_if.sv
// Start/code capture plus valid/ready digit stream between reader and consumer.
interface code_digit_reader_if
  import code_digit_reader_pkg::*;
#(
  parameter int DIGITS  = DIGITS_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF
);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int IDX_W  = idx_width(DIGITS);

  logic                start;
  logic [CODE_W-1:0]   code_i;
  logic [DIGIT_W-1:0]  digit_o;
  logic                digit_valid;
  logic                digit_ready;
  logic [IDX_W-1:0]    digit_idx;
  logic                busy;
  logic                done;

  // The reader itself.
  modport slave (
    input  start, code_i, digit_ready,
    output digit_o, digit_valid, digit_idx, busy, done
  );

  // Whoever launches transfers and consumes digits.
  modport master (
    output start, code_i, digit_ready,
    input  digit_o, digit_valid, digit_idx, busy, done
  );
endinterface

// File: rtl/code_digit_reader_digit_stage.sv
// One digit-wide register of the unload chain: parallel load or shift from the next stage.
module code_digit_reader_digit_stage #(
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               shift,
  input  logic [DIGIT_W-1:0] load_d,
  input  logic [DIGIT_W-1:0] shift_d,
  output logic [DIGIT_W-1:0] q
);
  logic [DIGIT_W-1:0] q_reg;

  // Clear beats load beats shift; otherwise hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_d;
    end else if (shift) begin
      q_reg <= shift_d;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/code_digit_reader.sv
// Captures a code word on start and unloads it digit by digit, oldest first.
module code_digit_reader
  import code_digit_reader_pkg::*;
#(
  parameter int DIGITS  = DIGITS_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  code_digit_reader_if.slave   bus
);
  localparam int IDX_W = idx_width(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   count_reg;
  logic               digit_valid_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               load_en;
  logic               shift_en;
  logic [DIGIT_W-1:0] stage_q [DIGITS];

  // Capture only from IDLE; advance the chain on every accepted digit.
  assign load_en  = (state_reg == ST_IDLE) && bus.start;
  assign shift_en = (state_reg == ST_SEND) && bus.digit_ready;

  // Stage gi holds digit gi; shifting moves each digit one stage toward stage 0.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_stage
      logic [DIGIT_W-1:0] shift_d;
      if (gi == DIGITS - 1) begin : g_top
        assign shift_d = '0;
      end else begin : g_mid
        assign shift_d = stage_q[gi+1];
      end
      code_digit_reader_digit_stage #(
        .DIGIT_W (DIGIT_W)
      ) u_stage (
        .clk     (clk),
        .clr     (clr),
        .load    (load_en),
        .shift   (shift_en),
        .load_d  (bus.code_i[gi*DIGIT_W +: DIGIT_W]),
        .shift_d (shift_d),
        .q       (stage_q[gi])
      );
    end
  endgenerate

  // Transfer FSM with digit counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg       <= ST_IDLE;
      count_reg       <= '0;
      digit_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg       <= ST_SEND;
            count_reg       <= '0;
            digit_valid_reg <= 1'b1;
            busy_reg        <= 1'b1;
          end
        end
        ST_SEND: begin
          if (bus.digit_ready) begin
            if (count_reg == LAST_IDX) begin
              state_reg       <= ST_DONE;
              count_reg       <= '0;
              digit_valid_reg <= 1'b0;
              done_reg        <= 1'b1;
            end else begin
              count_reg <= count_reg + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg       <= ST_IDLE;
          count_reg       <= '0;
          digit_valid_reg <= 1'b0;
          busy_reg        <= 1'b0;
          done_reg        <= 1'b0;
        end
      endcase
    end
  end

  // Digit bus is forced to zero whenever nothing is being offered.
  assign bus.digit_o     = digit_valid_reg ? stage_q[0] : '0;
  assign bus.digit_valid = digit_valid_reg;
  assign bus.digit_idx   = count_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
endmodule

// File: tb/tb_code_digit_reader.sv
// Directed bench for code_digit_reader: reset, unload, backpressure, ignored start, abort, back-to-back.
module tb_code_digit_reader;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  code_digit_reader_if bus_if ();

  code_digit_reader dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(bus_if.digit_valid), 32'd0);
    check({tag, ".digit"}, 32'(bus_if.digit_o), 32'd0);
    check({tag, ".idx"},   32'(bus_if.digit_idx), 32'd0);
    check({tag, ".busy"},  32'(bus_if.busy), 32'd0);
    check({tag, ".done"},  32'(bus_if.done), 32'd0);
  endtask

  task automatic check_digit(input string tag, input int k, input logic [3:0] exp_d);
    check($sformatf("%s.d%0d.valid", tag, k), 32'(bus_if.digit_valid), 32'd1);
    check($sformatf("%s.d%0d.digit", tag, k), 32'(bus_if.digit_o), 32'(exp_d));
    check($sformatf("%s.d%0d.idx", tag, k),   32'(bus_if.digit_idx), 32'(k));
    check($sformatf("%s.d%0d.busy", tag, k),  32'(bus_if.busy), 32'd1);
    check($sformatf("%s.d%0d.done", tag, k),  32'(bus_if.done), 32'd0);
  endtask

  // One transfer. exp_seq lists the expected digits in output order, first in the top nibble.
  // stall: ready-low cycles before each handshake. poke: re-assert start with 16'hFFFF mid-transfer.
  task automatic run_transfer(input string tag, input logic [15:0] code, input logic [15:0] exp_seq,
                              input int stall, input bit poke);
    logic [3:0] exp_d;
    bus_if.code_i      = code;
    bus_if.start       = 1'b1;
    bus_if.digit_ready = (stall == 0);
    step();
    bus_if.start  = 1'b0;
    bus_if.code_i = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      exp_d = exp_seq[15 - 4*k -: 4];
      if (poke && k == 1) begin
        bus_if.start  = 1'b1;
        bus_if.code_i = 16'hFFFF;
      end
      if (poke && k == 2) begin
        bus_if.start = 1'b0;
      end
      for (int s = 0; s < stall; s++) begin
        bus_if.digit_ready = 1'b0;
        check_digit($sformatf("%s.stall%0d", tag, s), k, exp_d);
        step();
      end
      check_digit(tag, k, exp_d);
      bus_if.digit_ready = 1'b1;
      step();
      bus_if.digit_ready = (stall == 0);
    end
    check({tag, ".done_pulse"}, 32'(bus_if.done), 32'd1);
    check({tag, ".done_busy"},  32'(bus_if.busy), 32'd1);
    check({tag, ".done_valid"}, 32'(bus_if.digit_valid), 32'd0);
    step();
    check_idle({tag, ".after"});
    step();
    check_idle({tag, ".after2"});
    bus_if.digit_ready = 1'b0;
  endtask

  initial begin
    bus_if.start       = 1'b0;
    bus_if.code_i      = '0;
    bus_if.digit_ready = 1'b0;

    // Reset with start asserted during clr.
    clr = 1'b1;
    bus_if.start  = 1'b1;
    bus_if.code_i = 16'h5555;
    step();
    step();
    check_idle("reset");
    clr = 1'b0;
    bus_if.start = 1'b0;
    step();
    check_idle("reset_release");

    run_transfer("basic", 16'h4321, 16'h1234, 0, 1'b0);
    run_transfer("backpressure", 16'hA5C3, 16'h3C5A, 3, 1'b0);
    run_transfer("ignored_start", 16'h1234, 16'h4321, 0, 1'b1);

    // Abort after the second handshake.
    bus_if.code_i      = 16'h8765;
    bus_if.start       = 1'b1;
    bus_if.digit_ready = 1'b1;
    step();
    bus_if.start = 1'b0;
    check_digit("abort", 0, 4'h5);
    step();
    check_digit("abort", 1, 4'h6);
    step();
    check_digit("abort", 2, 4'h7);
    clr = 1'b1;
    step();
    clr = 1'b0;
    bus_if.digit_ready = 1'b0;
    check_idle("abort_clr");
    step();
    check_idle("abort_no_done");
    run_transfer("after_abort", 16'h0009, 16'h9000, 0, 1'b0);

    // Back-to-back with start held high; code_i is scrambled right after each start edge.
    begin
      logic [15:0] codes [3];
      logic [15:0] exps  [3];
      codes[0] = 16'h2468; exps[0] = 16'h8642;
      codes[1] = 16'h1357; exps[1] = 16'h7531;
      codes[2] = 16'hBEEF; exps[2] = 16'hFEEB;
      bus_if.digit_ready = 1'b1;
      bus_if.start       = 1'b1;
      bus_if.code_i      = codes[0];
      step();
      for (int tr = 0; tr < 3; tr++) begin
        logic [15:0] e;
        e = exps[tr];
        bus_if.code_i = 16'hEEEE;
        for (int k = 0; k < 4; k++) begin
          check_digit($sformatf("b2b%0d", tr), k, e[15 - 4*k -: 4]);
          step();
        end
        check($sformatf("b2b%0d.done", tr), 32'(bus_if.done), 32'd1);
        step();
        check($sformatf("b2b%0d.idle_valid", tr), 32'(bus_if.digit_valid), 32'd0);
        check($sformatf("b2b%0d.idle_busy", tr), 32'(bus_if.busy), 32'd0);
        if (tr < 2) begin
          bus_if.code_i = codes[tr+1];
        end else begin
          bus_if.start = 1'b0;
        end
        step();
      end
      check_idle("b2b_end");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
